// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-side bundle for seg7_scan.
//   min_bcd    : packed BCD minutes, [7:4] tens, [3:0] ones
//   sec_bcd    : packed BCD seconds, [7:4] tens, [3:0] ones
//   blank_lead : suppress a zero on digit 3 (minutes tens)
//   an         : active-low anode enables, an[i] = 0 lights digit i
//   seg        : active-low segments, [6:0] = g f e d c b a
//   dp         : active-low decimal point
// The master drives the BCD values and watches the display lines; the slave is the scanner.
interface seg7_scan_if;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output min_bcd,
    output sec_bcd,
    output blank_lead,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  min_bcd,
    input  sec_bcd,
    input  blank_lead,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed seven-segment driver for a mm.ss BCD clock.
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset
//   bus_io : seg7_scan_if slave (BCD inputs, blank_lead, an/seg/dp outputs)
// Each digit stays lit for SCAN_DIV cycles; digits 0..3 are sec ones, sec tens, min ones,
// min tens. Both BCD bytes are captured together at the start of every frame so a digit
// pair is never shown half-updated. All display outputs are registered and follow the
// scan position and snapshot of the previous cycle.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DP_DIGIT = 2
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus_io
);

  localparam int unsigned CntW    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(SCAN_DIV - 1);
  localparam logic [1:0]      DpIdx   = 2'(DP_DIGIT);
  localparam logic [6:0]      SegOff  = 7'b1111111;

  // Active-low seven-segment decode; anything outside 0..9 goes dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegOff;
    endcase
    return s;
  endfunction

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_q, snap_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            div_wrap;
  logic            frame_start;
  logic [3:0]      digit;

  // Dwell divider, scan index and frame snapshot.
  always_comb begin
    div_wrap    = (div_cnt_q == DivLast);
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + CntW'(1);
    idx_d       = div_wrap ? idx_q + 2'd1 : idx_q;
    frame_start = (div_cnt_q == '0) && (idx_q == 2'd0);
    snap_d      = frame_start ? {bus_io.min_bcd, bus_io.sec_bcd} : snap_q;
  end

  // Output decode from the current index and snapshot; registered below, giving the
  // one-cycle latency. This means the first cycle of digit 0 still shows the snapshot
  // from before this frame's capture.
  always_comb begin
    digit = 4'd0;
    unique case (idx_q)
      2'd0: digit = snap_q[3:0];
      2'd1: digit = snap_q[7:4];
      2'd2: digit = snap_q[11:8];
      2'd3: digit = snap_q[15:12];
      default: digit = 4'd0;
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = bcd_to_seg(digit);
    // Leading-zero suppression uses the live blank_lead; the anode stays on.
    if (bus_io.blank_lead && (idx_q == 2'd3) && (digit == 4'd0)) begin
      seg_d = SegOff;
    end
    dp_d = (idx_q == DpIdx) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      an_q      <= 4'b1111;
      seg_q     <= SegOff;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus_io.an  = an_q;
  assign bus_io.seg = seg_q;
  assign bus_io.dp  = dp_q;

endmodule
